// File: rtl/fifo_dma_drain_ctrl_if.sv
// FIFO-head and memory-write signals between the drain controller and its neighbours.
// Port names keep their controller-side direction suffixes so both ends read the same.
interface fifo_dma_drain_ctrl_if #(
   parameter int C_WIDTH  = 64,
   parameter int C_ADDR_W = 32
);
   logic [C_WIDTH-1:0]  fifo_data_i;
   logic                fifo_empty_i;
   logic                fifo_pop_o;
   logic                mem_valid_o;
   logic                mem_ready_i;
   logic [C_ADDR_W-1:0] mem_addr_o;
   logic [C_WIDTH-1:0]  mem_data_o;

   modport master (
      input  fifo_data_i, fifo_empty_i, mem_ready_i,
      output fifo_pop_o, mem_valid_o, mem_addr_o, mem_data_o
   );

   modport slave (
      output fifo_data_i, fifo_empty_i, mem_ready_i,
      input  fifo_pop_o, mem_valid_o, mem_addr_o, mem_data_o
   );
endinterface

// File: rtl/fifo_dma_drain_ctrl.sv
// Drains one transfer of words from an FWFT FIFO onto a memory write port.
// Define DMA_RING_EN to wrap the word offset inside a C_RING_WORDS window.
module fifo_dma_drain_ctrl #(
   parameter int C_WIDTH      = 64,
   parameter int C_ADDR_W     = 32,
   parameter int C_LEN_W      = 16,
   parameter int C_RING_WORDS = 256
) (
   input  logic                clk_i,
   input  logic                rstn_i,
   input  logic [C_ADDR_W-1:0] cfg_addr_i,
   input  logic [C_LEN_W-1:0]  cfg_len_i,
   input  logic                start_i,
   input  logic                abort_i,
   output logic                busy_o,
   output logic                done_o,
   output logic                aborted_o,
   output logic [C_LEN_W-1:0]  words_done_o,
   fifo_dma_drain_ctrl_if.master bus
);

   localparam int                  BYTE_SHIFT = $clog2(C_WIDTH / 8);
   localparam logic [C_ADDR_W-1:0] WORD_BYTES = C_ADDR_W'(C_WIDTH / 8);
   localparam logic [C_ADDR_W-1:0] ALIGN_MASK = ~C_ADDR_W'(C_WIDTH / 8 - 1);

   typedef enum logic [1:0] {IDLE, XFER, DONE} state_t;

   state_t              state, state_nxt;
   logic [C_LEN_W-1:0]  len_q;
   logic [C_LEN_W-1:0]  words_q;
   logic                aborted_q;
   logic                handshake;
   logic                start_ok;
   logic [C_ADDR_W-1:0] addr_out;

   assign start_ok = (state == IDLE) && start_i && (cfg_len_i != '0);

   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) state <= IDLE;
      else         state <= state_nxt;
   end

   always_comb begin
      state_nxt       = state;
      busy_o          = 1'b0;
      done_o          = 1'b0;
      handshake       = 1'b0;
      bus.mem_valid_o = 1'b0;
      bus.fifo_pop_o  = 1'b0;
      case (state)
         IDLE: begin
            if (start_i) state_nxt = (cfg_len_i == '0) ? DONE : XFER;
         end
         XFER: begin
            busy_o          = 1'b1;
            bus.mem_valid_o = !bus.fifo_empty_i;
            handshake       = !bus.fifo_empty_i && bus.mem_ready_i;
            bus.fifo_pop_o  = handshake;
            // Abort takes the same exit as completion; a word accepted this cycle still counts.
            if (abort_i || (handshake && (words_q == len_q - C_LEN_W'(1))))
               state_nxt = DONE;
         end
         DONE: begin
            done_o    = 1'b1;
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         len_q     <= '0;
         words_q   <= '0;
         aborted_q <= 1'b0;
      end else begin
         if (start_ok) begin
            len_q   <= cfg_len_i;
            words_q <= '0;
         end else if (handshake) begin
            words_q <= words_q + C_LEN_W'(1);
         end
         if ((state == IDLE) && start_i)        aborted_q <= 1'b0;
         else if ((state == XFER) && abort_i)   aborted_q <= 1'b1;
      end
   end

`ifdef DMA_RING_EN
   localparam int RING_LOG2 = $clog2(C_RING_WORDS);

   logic [C_ADDR_W-1:0]  base_q;
   logic [RING_LOG2-1:0] ring_off_q;

   // The offset counter is exactly ring-sized, so it wraps to 0 on its own.
   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         base_q     <= '0;
         ring_off_q <= '0;
      end else if (start_ok) begin
         base_q     <= cfg_addr_i & ALIGN_MASK;
         ring_off_q <= '0;
      end else if (handshake) begin
         ring_off_q <= ring_off_q + RING_LOG2'(1);
      end
   end

   assign addr_out = base_q + (C_ADDR_W'(ring_off_q) << BYTE_SHIFT);
`else
   logic [C_ADDR_W-1:0] addr_q;

   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i)        addr_q <= '0;
      else if (start_ok)  addr_q <= cfg_addr_i & ALIGN_MASK;
      else if (handshake) addr_q <= addr_q + WORD_BYTES;
   end

   assign addr_out = addr_q;
`endif

   assign bus.mem_addr_o = addr_out;
   assign bus.mem_data_o = bus.fifo_data_i;
   assign words_done_o   = words_q;
   assign aborted_o      = aborted_q;

endmodule

// File: tb/tb_fifo_dma_drain_ctrl.sv
// Scoreboard bench for fifo_dma_drain_ctrl: a queue-based FIFO model feeds the DUT,
// a transaction-level model predicts writes, and a negedge monitor compares them.
module tb_fifo_dma_drain_ctrl;
   localparam int W    = 64;
   localparam int AW   = 32;
   localparam int LW   = 16;
   localparam int RING = 4;

   logic          clk_i = 1'b0;
   logic          rstn_i = 1'b0;
   logic [AW-1:0] cfg_addr_i = '0;
   logic [LW-1:0] cfg_len_i = '0;
   logic          start_i = 1'b0;
   logic          abort_i = 1'b0;
   logic          busy_o, done_o, aborted_o;
   logic [LW-1:0] words_done_o;

   fifo_dma_drain_ctrl_if #(.C_WIDTH(W), .C_ADDR_W(AW)) bus ();

   fifo_dma_drain_ctrl #(
      .C_WIDTH(W), .C_ADDR_W(AW), .C_LEN_W(LW), .C_RING_WORDS(RING)
   ) dut (
      .clk_i(clk_i), .rstn_i(rstn_i),
      .cfg_addr_i(cfg_addr_i), .cfg_len_i(cfg_len_i),
      .start_i(start_i), .abort_i(abort_i),
      .busy_o(busy_o), .done_o(done_o), .aborted_o(aborted_o),
      .words_done_o(words_done_o),
      .bus(bus)
   );

   always #5 clk_i = ~clk_i;

   int            n_vec = 0;
   int            n_err = 0;
   logic [W-1:0]  fifo_q[$];
   logic [W-1:0]  exp_data_q[$];
   logic [AW-1:0] exp_addr_q[$];
   bit            pop_pending = 1'b0;
   bit            done_seen = 1'b0;
   bit            m_busy = 1'b0, m_done = 1'b0, m_aborted = 1'b0, m_zero = 1'b0;
   int            m_count = 0, m_len = 0;

   task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("[TB] FAIL %s: actual %0h required %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Word k of a transfer lands at the aligned base plus its (optionally ring-wrapped) offset.
   function automatic logic [AW-1:0] exp_addr(input logic [AW-1:0] base, input int k);
      int off;
`ifdef DMA_RING_EN
      off = k % RING;
`else
      off = k;
`endif
      return (base & ~32'h7) + AW'(off * 8);
   endfunction

   task automatic refresh_fifo();
      bus.fifo_empty_i = (fifo_q.size() == 0);
      bus.fifo_data_i  = (fifo_q.size() != 0) ? fifo_q[0] : '0;
   endtask

   task automatic push_word(input logic [W-1:0] w);
      fifo_q.push_back(w);
      exp_data_q.push_back(w);
      refresh_fifo();
   endtask

   task automatic flush_fifo();
      fifo_q.delete();
      exp_data_q.delete();
      refresh_fifo();
   endtask

   task automatic tick();
      @(posedge clk_i);
      #1;
      if (pop_pending && fifo_q.size() != 0) void'(fifo_q.pop_front());
      pop_pending = 1'b0;
      refresh_fifo();
   endtask

   always @(negedge clk_i) begin : monitor
      bit ev, eh, nd;
      if (!rstn_i) begin
         m_busy = 0; m_done = 0; m_aborted = 0; m_zero = 0; m_count = 0;
         pop_pending = 0;
         exp_addr_q.delete();
      end else begin
         check_output("busy", busy_o, m_busy);
         check_output("done", done_o, m_done);
         if (done_o) done_seen = 1'b1;
         if (m_done) begin
            check_output("aborted", aborted_o, m_aborted);
            if (!m_zero) check_output("words_done", words_done_o, 64'(m_count));
         end
         ev = m_busy && (fifo_q.size() != 0);
         eh = ev && bus.mem_ready_i;
         check_output("mem_valid", bus.mem_valid_o, ev);
         check_output("fifo_pop", bus.fifo_pop_o, eh);
         pop_pending = bus.fifo_pop_o;
         if (eh) begin
            if (exp_addr_q.size() == 0 || exp_data_q.size() == 0) begin
               check_output("write_unexpected", 1, 0);
            end else begin
               check_output("mem_addr", bus.mem_addr_o, exp_addr_q.pop_front());
               check_output("mem_data", bus.mem_data_o, exp_data_q.pop_front());
            end
            m_count++;
         end
         nd = 1'b0;
         if (m_busy) begin
            if (abort_i) begin
               m_busy = 0; nd = 1; m_aborted = 1;
            end else if (eh && m_count == m_len) begin
               m_busy = 0; nd = 1;
            end
         end else if (!m_done && start_i) begin
            m_aborted = 0;
            if (cfg_len_i == '0) begin
               nd = 1; m_zero = 1;
            end else begin
               m_busy = 1; m_zero = 0; m_count = 0; m_len = int'(cfg_len_i);
               exp_addr_q.delete();
               for (int k = 0; k < m_len; k++) exp_addr_q.push_back(exp_addr(cfg_addr_i, k));
            end
         end
         m_done = nd;
      end
   end

   // One transfer; feed_period 0 preloads every word before start.
   task automatic apply_stimulus(input logic [AW-1:0] addr, input int len, input int ready_prob,
                                 input int feed_period, input int abort_prob);
      logic [W-1:0] pend[$];
      int cyc;
      for (int i = 0; i < len; i++) pend.push_back({$urandom, $urandom});
      if (feed_period == 0) while (pend.size() != 0) push_word(pend.pop_front());
      cfg_addr_i = addr; cfg_len_i = LW'(len); start_i = 1'b1; done_seen = 1'b0;
      bus.mem_ready_i = ($urandom_range(99) < ready_prob);
      tick();
      start_i = 1'b0;
      cyc = 0;
      while (!done_seen && cyc < 500) begin
         bus.mem_ready_i = ($urandom_range(99) < ready_prob);
         if (pend.size() != 0 && feed_period > 0 && (cyc % feed_period) == 0)
            push_word(pend.pop_front());
         abort_i = ($urandom_range(99) < abort_prob);
         start_i = ($urandom_range(15) == 0);
         if (start_i) cfg_len_i = LW'($urandom_range(1, 9));
         tick();
         cyc++;
      end
      start_i = 1'b0; abort_i = 1'b0; bus.mem_ready_i = 1'b0;
      check_output("done_within_budget", done_seen, 1);
      flush_fifo();
      tick();
   endtask

   initial begin
      bus.mem_ready_i = 1'b0;
      refresh_fifo();
      #1;
      check_output("rst_busy", busy_o, 0);
      check_output("rst_done", done_o, 0);
      check_output("rst_aborted", aborted_o, 0);
      check_output("rst_mem_valid", bus.mem_valid_o, 0);
      check_output("rst_pop", bus.fifo_pop_o, 0);
      check_output("rst_mem_addr", bus.mem_addr_o, 0);
      check_output("rst_words_done", words_done_o, 0);
      tick(); tick();
      rstn_i = 1'b1;
      tick();

      $display("[TB] basic preloaded transfer");
      apply_stimulus(32'h1000, 4, 100, 0, 0);

      $display("[TB] backpressure and underflow");
      apply_stimulus(32'h6000, 3, 50, 3, 0);

      $display("[TB] zero length");
      apply_stimulus(32'h5000, 0, 100, 1, 0);

      $display("[TB] abort on third handshake");
      for (int i = 0; i < 8; i++) push_word({$urandom, $urandom});
      cfg_addr_i = 32'h2000; cfg_len_i = 16'd8; start_i = 1'b1;
      bus.mem_ready_i = 1'b1; done_seen = 1'b0;
      tick(); start_i = 1'b0;
      tick();
      start_i = 1'b1; cfg_len_i = 16'd5;
      tick();
      start_i = 1'b0; abort_i = 1'b1;
      tick();
      abort_i = 1'b0;
      tick();
      check_output("abort_done_seen", done_seen, 1);
      check_output("abort_fifo_left", 64'(fifo_q.size()), 5);
      bus.mem_ready_i = 1'b0;
      flush_fifo();
      tick();

      $display("[TB] async reset mid-transfer");
      for (int i = 0; i < 5; i++) push_word({$urandom, $urandom});
      cfg_addr_i = 32'h3000; cfg_len_i = 16'd5; start_i = 1'b1;
      bus.mem_ready_i = 1'b1;
      tick(); start_i = 1'b0;
      tick();
      tick();
      #2 rstn_i = 1'b0;
      #1;
      check_output("arst_busy", busy_o, 0);
      check_output("arst_done", done_o, 0);
      check_output("arst_mem_valid", bus.mem_valid_o, 0);
      check_output("arst_pop", bus.fifo_pop_o, 0);
      check_output("arst_mem_addr", bus.mem_addr_o, 0);
      check_output("arst_words_done", words_done_o, 0);
      check_output("arst_fifo_left", 64'(fifo_q.size()), 3);
      tick(); tick();
      rstn_i = 1'b1;
      bus.mem_ready_i = 1'b0;
      flush_fifo();
      tick();
      apply_stimulus(32'h4000, 1, 100, 1, 0);

      $display("[TB] ring window addressing");
      apply_stimulus(32'h100, 6, 100, 0, 0);

      $display("[TB] randomized transfers");
      for (int t = 0; t < 40; t++) begin
         int len;
         logic [AW-1:0] base;
         len  = ($urandom_range(9) == 0) ? 0 : int'($urandom_range(1, 12));
         base = ($urandom_range(7) == 0) ? 32'hFFFF_FFE3 : AW'($urandom);
         apply_stimulus(base, len, int'($urandom_range(30, 100)), int'($urandom_range(0, 3)),
                        ($urandom_range(3) == 0) ? 4 : 0);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
